// File: rtl/bicycle_pkg.sv
// Shared types and default widths for the bicycle computer and its reed-sensor emulator.
package bicycle_pkg;

   localparam int unsigned DEF_PERIOD_WIDTH = 16;
   localparam int unsigned DEF_HIGH_WIDTH   = 8;
   localparam int unsigned DEF_BOUNCE_WIDTH = 4;
   localparam int unsigned DEF_COUNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      StIdle,
      StBounce,
      StHigh,
      StLow
   } state_t;

endpackage

// File: rtl/reed_pulse_gen_if.sv
// Configuration/run-control and status bundle of the reed pulse generator.
interface reed_pulse_gen_if #(
   parameter int unsigned PERIOD_WIDTH = bicycle_pkg::DEF_PERIOD_WIDTH,
   parameter int unsigned HIGH_WIDTH   = bicycle_pkg::DEF_HIGH_WIDTH,
   parameter int unsigned BOUNCE_WIDTH = bicycle_pkg::DEF_BOUNCE_WIDTH,
   parameter int unsigned COUNT_WIDTH  = bicycle_pkg::DEF_COUNT_WIDTH
) ();

   logic                    enable;
   logic                    load;
   logic [PERIOD_WIDTH-1:0] period;
   logic [HIGH_WIDTH-1:0]   high_len;
   logic [BOUNCE_WIDTH-1:0] bounce;
   logic                    reed;
   logic                    rev_pulse;
   logic [COUNT_WIDTH-1:0]  rev_count;
   logic                    busy;

   modport master (
      output enable, load, period, high_len, bounce,
      input  reed, rev_pulse, rev_count, busy
   );

   modport slave (
      input  enable, load, period, high_len, bounce,
      output reed, rev_pulse, rev_count, busy
   );

endinterface

// File: rtl/reed_pulse_gen.sv
// Wheel-sensor emulator: drives a bouncing reed closure once per programmable revolution period.
// Outputs are registered from the FSM state, so they trail the state/tick by one cycle.
module reed_pulse_gen
   import bicycle_pkg::*;
#(
   parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH,
   parameter int unsigned HIGH_WIDTH   = DEF_HIGH_WIDTH,
   parameter int unsigned BOUNCE_WIDTH = DEF_BOUNCE_WIDTH,
   parameter int unsigned COUNT_WIDTH  = DEF_COUNT_WIDTH
) (
   input logic             i_clock,
   input logic             i_reset,
   reed_pulse_gen_if.slave bus
);

   state_t                  r_state, w_state_nxt;
   logic [PERIOD_WIDTH-1:0] r_tick, w_tick_nxt, w_tick_inc;
   logic [PERIOD_WIDTH-1:0] r_sh_period;
   logic [HIGH_WIDTH-1:0]   r_sh_high;
   logic [BOUNCE_WIDTH-1:0] r_sh_bounce;
   // Active revolution config: period, end of bounce, end of steady high.
   logic [PERIOD_WIDTH-1:0] r_p, r_bend, r_hend;
   logic                    r_reed, r_pulse, r_busy;
   logic [COUNT_WIDTH-1:0]  r_rev_count;

   logic [PERIOD_WIDTH-1:0] w_src_period;
   logic [HIGH_WIDTH-1:0]   w_src_high;
   logic [BOUNCE_WIDTH-1:0] w_src_bounce;
   logic [PERIOD_WIDTH:0]   w_h_x, w_b2_x, w_hend_x, w_minp_x, w_per_x, w_p_x;
   logic [PERIOD_WIDTH-1:0] w_eff_p, w_eff_bend, w_eff_hend;
   logic                    w_start_ok, w_start, w_last;
   logic                    w_reed_nxt, w_pulse_nxt;

   function automatic logic [PERIOD_WIDTH-1:0] sat_fn(input logic [PERIOD_WIDTH:0] v);
      return v[PERIOD_WIDTH] ? '1 : v[PERIOD_WIDTH-1:0];
   endfunction

   // Effective config for a revolution starting now; a coincident load bypasses the shadows.
   always_comb begin
      w_src_period = bus.load ? bus.period   : r_sh_period;
      w_src_high   = bus.load ? bus.high_len : r_sh_high;
      w_src_bounce = bus.load ? bus.bounce   : r_sh_bounce;
      w_h_x        = (w_src_high == '0) ? (PERIOD_WIDTH+1)'(1) : (PERIOD_WIDTH+1)'(w_src_high);
      w_b2_x       = (PERIOD_WIDTH+1)'(w_src_bounce) << 1;
      w_hend_x     = w_b2_x + w_h_x;
      w_minp_x     = w_hend_x + (PERIOD_WIDTH+1)'(1);
      w_per_x      = {1'b0, w_src_period};
      w_p_x        = (w_per_x > w_minp_x) ? w_per_x : w_minp_x;
      w_eff_p      = sat_fn(w_p_x);
      w_eff_bend   = sat_fn(w_b2_x);
      w_eff_hend   = sat_fn(w_hend_x);
   end

   // Next state/tick and the output values decoded from the current state/tick.
   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_start     = 1'b0;
      w_start_ok  = bus.enable && (w_src_period != '0);
      w_tick_inc  = r_tick + PERIOD_WIDTH'(1);
      w_last      = (r_tick == r_p - PERIOD_WIDTH'(1));
      unique case (r_state)
         StIdle: begin
            if (w_start_ok) w_start = 1'b1;
         end
         StBounce, StHigh, StLow: begin
            if (w_last) begin
               if (w_start_ok) begin
                  w_start = 1'b1;
               end else begin
                  w_state_nxt = StIdle;
                  w_tick_nxt  = '0;
               end
            end else begin
               w_tick_nxt = w_tick_inc;
               if (w_tick_inc < r_bend)      w_state_nxt = StBounce;
               else if (w_tick_inc < r_hend) w_state_nxt = StHigh;
               else                          w_state_nxt = StLow;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
      if (w_start) begin
         w_tick_nxt  = '0;
         w_state_nxt = (w_eff_bend != '0) ? StBounce : StHigh;
      end

      w_reed_nxt = 1'b0;
      case (r_state)
         StBounce: w_reed_nxt = ~r_tick[0];
         StHigh:   w_reed_nxt = 1'b1;
         default:  w_reed_nxt = 1'b0;
      endcase
      w_pulse_nxt = (r_state != StIdle) && (r_tick == '0);
   end

   // FSM state and intra-revolution tick.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= StIdle;
         r_tick  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tick  <= w_tick_nxt;
      end
   end

   // Shadow/active config, registered outputs and revolution counter.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_sh_period <= '0;
         r_sh_high   <= '0;
         r_sh_bounce <= '0;
         r_p         <= '0;
         r_bend      <= '0;
         r_hend      <= '0;
         r_reed      <= 1'b0;
         r_pulse     <= 1'b0;
         r_busy      <= 1'b0;
         r_rev_count <= '0;
      end else begin
         if (bus.load) begin
            r_sh_period <= bus.period;
            r_sh_high   <= bus.high_len;
            r_sh_bounce <= bus.bounce;
         end
         if (w_start) begin
            r_p    <= w_eff_p;
            r_bend <= w_eff_bend;
            r_hend <= w_eff_hend;
         end
         r_reed  <= w_reed_nxt;
         r_pulse <= w_pulse_nxt;
         r_busy  <= (r_state != StIdle);
         if (w_pulse_nxt) r_rev_count <= r_rev_count + COUNT_WIDTH'(1);
      end
   end

   assign bus.reed      = r_reed;
   assign bus.rev_pulse = r_pulse;
   assign bus.rev_count = r_rev_count;
   assign bus.busy      = r_busy;

endmodule

// File: doc/reed_pulse_gen.md
Name: reed_pulse_gen

Overview:
Wheel-sensor emulator. It is the transmitter for the reed input of the bicycle computer.
- Generates reed closures at a programmable revolution period, closure length and contact-bounce count.
- Provides revolution bookkeeping so benches and the FPGA demo harness can check speed, distance and average-speed results against known wheel motion.
- Sits beside the bicycle top; its reed output drives the top's reed input.

Parameters:
PERIOD_WIDTH, 16, width of period and of the intra-revolution tick counter
HIGH_WIDTH, 8, width of closure-length field
BOUNCE_WIDTH, 4, width of bounce-count field
COUNT_WIDTH, 16, width of revolution counter

Ports:
clock  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
enable  in  1  run request; sampled only in IDLE and at revolution boundaries
load  in  1  one-cycle strobe; captures period/high_len/bounce into shadow registers
period  in  PERIOD_WIDTH  clock ticks from one revolution start to the next; 0 = stopped
high_len  in  HIGH_WIDTH  ticks reed is held steadily high after bounce; 0 treated as 1
bounce  in  BOUNCE_WIDTH  number of 1/0 glitch pairs preceding steady closure
reed  out  1  emulated reed contact, registered
rev_pulse  out  1  one-cycle strobe in the first cycle of each revolution, coincident with first reed high
rev_count  out  COUNT_WIDTH  revolutions started since reset; wraps to 0
busy  out  1  high while not in IDLE

Behaviour:
- Reset (synchronous, active-high): state IDLE; reed=0, rev_pulse=0, rev_count=0, busy=0; shadow registers and tick counter cleared. Reset mid-revolution drops reed to 0 at the same edge.
- Shadow config
  - load captures inputs into sh_period, sh_high, sh_bounce.
  - The active config is latched from the shadows only at revolution start.
  - If load coincides with a revolution start, the newly loaded values are used for that revolution (bypass).
- Effective values, computed at revolution start:
  - H = max(sh_high, 1); B = sh_bounce
  - P = max(sh_period, 2B+H+1), so at least one low tick per revolution.
  - Arithmetic is done at PERIOD_WIDTH+1 bits, then saturates to all-ones.
- FSM states: IDLE, BOUNCE, HIGH, LOW.
  - IDLE -> revolution start when enable=1 and active period≠0 (load bypass applies). Outputs are registered: enable seen at edge t gives reed=1 and rev_pulse=1 after edge t+1. With enable=1 and period=0, stay in IDLE.
  - Revolution start: tick=0; rev_count+1 (wrap); rev_pulse=1; next state BOUNCE if B>0, else HIGH.
  - BOUNCE, ticks 0..2B-1: reed = 1 on even ticks, 0 on odd ticks.
  - HIGH, ticks 2B..2B+H-1: reed=1.
  - LOW, ticks 2B+H..P-1: reed=0.
  - At tick P-1: if enable=1 and active period≠0, the next cycle is a revolution start (back-to-back, no gap). Otherwise go to IDLE.
- Mid-revolution behaviour:
  - enable deassertion never truncates a revolution; the full P ticks complete before IDLE.
  - load mid-revolution does not affect the current revolution.
- busy=1 in BOUNCE, HIGH, LOW; busy=0 in IDLE.
- rev_pulse is never asserted outside a revolution start.
- Steady-state revolution rate = 1/P clock ticks exactly.

Decomposition:
- Shared package bicycle_pkg:
  - state enumeration (IDLE/BOUNCE/HIGH/LOW)
  - default width constants (PERIOD_WIDTH, HIGH_WIDTH, BOUNCE_WIDTH, COUNT_WIDTH)
- No sub-module needed. The effective-value/saturation arithmetic is kept as a local function inside the block.

Test Plan:
- period=10, high_len=3, bounce=0, load, enable -> reed high ticks 0-2 of every 10-tick window; rev_pulse every 10 cycles; rev_count 1,2,3...; busy=1 continuously.
- period=12, high_len=3, bounce=2 -> reed per revolution: 1,0,1,0,1,1,1,0,0,0,0,0; rev_pulse on tick 0 only.
- period=4, high_len=5, bounce=0 -> effective P=6: 5 high ticks, 1 low tick per revolution. high_len=0, period=5 -> 1 high tick, 4 low ticks.
- Config change timing:
  - running P=10, load period=20 at tick 4 -> current revolution still 10 ticks; next revolution 20 ticks.
  - load period=20 exactly at a revolution start -> that revolution is already 20 ticks.
- enable low at tick 1 of a P=10 revolution -> revolution completes through tick 9, then reed=0 and busy=0; no further rev_pulse.
- reset at tick 1 (reed high) -> reed=0, rev_count=0, state IDLE after that edge.
- period=0 with enable=1 -> reed stays 0, busy=0.
- Force 65535 revolutions -> rev_count wraps 65535->0 on the next revolution start.
